// File: rtl/fifo36k_wr_arbiter.sv
// fifo36k_wr_arbiter
//
// Round-robin write-port arbiter and reset sequencer for one synchronous FIFO36K.
// Shares the FIFO write port among NUM_REQ valid/ready requesters, sequences the
// FIFO RESET pin (RST -> SETTLE -> RUN) after power-on and on FLUSH, never issues
// a write the FIFO cannot absorb, and keeps a sticky copy of the FIFO overflow flag.
//
// Optional feature: define FIFO36K_WR_ARB_BURST_LOCK_EN to add i_req_last and hold
// the grant on one requester until its last beat has been accepted.
//
// Ports:
//   i_clk               clock, also the FIFO WR_CLK
//   i_rst_n             asynchronous active-low reset
//   i_req_valid         per-requester beat valid
//   i_req_data          requester i on [i*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready         one-hot or zero grant (combinational)
//   i_req_last          last beat of a burst (burst-lock build only)
//   i_flush             starts a FIFO reset sequence when seen in RUN
//   i_fifo_full         FIFO FULL
//   i_fifo_almost_full  FIFO ALMOSTFULL
//   i_fifo_overflow     FIFO WRERR / overflow
//   o_fifo_reset        FIFO RESET
//   o_fifo_wr_en        FIFO WREN (registered)
//   o_fifo_wr_data      FIFO DI (registered)
//   o_grant_id          requester of the most recently accepted beat
//   o_busy              high whenever not in RUN
//   o_err_overflow      sticky overflow flag, cleared by reset or a flush

module fifo36k_wr_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 36,
    parameter int unsigned RESET_CYCLES  = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
    input  logic [NUM_REQ-1:0]            i_req_last,
`endif
    input  logic                          i_flush,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_almost_full,
    input  logic                          i_fifo_overflow,
    output logic                          o_fifo_reset,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy,
    output logic                          o_err_overflow
);

    localparam int unsigned IDW     = $clog2(NUM_REQ);
    localparam int unsigned CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES
                                                                     : SETTLE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0]  RST_LAST    = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [IDW-1:0] ID_MAX      = IDW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StRst    = 2'd0,
        StSettle = 2'd1,
        StRun    = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_d;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_d;

    logic                  r_wr_en;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [IDW-1:0]        r_grant_id;
    logic [IDW-1:0]        r_ptr;
    logic                  r_err;

    logic                  w_space;
    logic                  w_grant_en;
    logic                  w_found;
    logic                  w_accept;
    logic [IDW-1:0]        w_idx;
    logic [IDW-1:0]        w_gnt_id;
    logic [IDW-1:0]        w_ptr_next;
    logic [DATA_WIDTH-1:0] w_data;

`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
    logic                  r_locked;
    logic [IDW-1:0]        r_lock_id;
`endif

    // ------------------------------------------------------------------
    // Reset / settle sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StRst;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StRst: begin
                if (r_cnt == RST_LAST) begin
                    w_state_d = StSettle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StSettle: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CW'(1);
                end
            end
            StRun: begin
                if (i_flush) begin
                    w_state_d = StRst;
                    w_cnt_d   = '0;
                end
            end
            default: begin
                w_state_d = StRst;
                w_cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A registered write already in flight will land first, so almost-full plus a
    // pending write means the FIFO has no room for another beat.
    assign w_space    = !i_fifo_full && !(r_wr_en && i_fifo_almost_full);
    assign w_grant_en = (r_state == StRun) && !i_flush && w_space;

    always_comb begin
        w_found     = 1'b0;
        w_gnt_id    = '0;
        w_idx       = '0;
        o_req_ready = '0;
        // First valid requester at or after the pointer, wrapping.
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = IDW'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_found && i_req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx;
            end
        end
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
        // A locked burst owns the port even while its owner is idle.
        if (r_locked) begin
            w_found  = i_req_valid[r_lock_id];
            w_gnt_id = r_lock_id;
        end
`endif
        w_accept = w_found && w_grant_en;
        if (w_accept) begin
            o_req_ready[w_gnt_id] = 1'b1;
        end
    end

    assign w_ptr_next = (w_gnt_id == ID_MAX) ? '0 : w_gnt_id + IDW'(1);
    assign w_data     = i_req_data[32'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];

    // ------------------------------------------------------------------
    // Write port, pointer and overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_data  <= '0;
            r_grant_id <= '0;
            r_ptr      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_data  <= w_data;
                r_grant_id <= w_gnt_id;
            end
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
            if (w_accept && i_req_last[w_gnt_id]) begin
                r_ptr <= w_ptr_next;
            end
`else
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
`endif
            // Flush in RUN is the only way into RST besides reset; it clears the flag.
            if (r_state == StRun) begin
                if (i_flush) begin
                    r_err <= 1'b0;
                end else if (i_fifo_overflow) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_locked  <= 1'b0;
            r_lock_id <= '0;
        end else if (r_state != StRun || i_flush) begin
            r_locked <= 1'b0;
        end else if (w_accept) begin
            r_locked  <= !i_req_last[w_gnt_id];
            r_lock_id <= w_gnt_id;
        end
    end
`endif

    assign o_fifo_reset   = (r_state == StRst);
    assign o_busy         = (r_state != StRun);
    assign o_fifo_wr_en   = r_wr_en;
    assign o_fifo_wr_data = r_wr_data;
    assign o_grant_id     = r_grant_id;
    assign o_err_overflow = r_err;

endmodule

// File: tb/tb_fifo36k_wr_arbiter.sv
// Self-checking bench for fifo36k_wr_arbiter. A 1024-deep FIFO stub supplies the
// full / almost-full flags; a cycle-level reference model tracks the expected
// sequencer phase, round-robin order and write port.
module tb_fifo36k_wr_arbiter;
    localparam int N     = 4;
    localparam int DW    = 36;
    localparam int RC    = 4;
    localparam int SC    = 2;
    localparam int IDW   = 2;
    localparam int DEPTH = 1024;
    localparam int OW    = N + 1 + IDW + 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    valid = '0;
    logic [N-1:0]    last = '0;
    logic [N*DW-1:0] data_bus = '0;
    logic            flush = 1'b0;
    logic            ovf_in = 1'b0;
    logic            rd = 1'b0;
    logic [DW-1:0]   req_data [N];

    logic [N-1:0]    o_req_ready;
    logic            o_fifo_reset;
    logic            o_fifo_wr_en;
    logic [DW-1:0]   o_fifo_wr_data;
    logic [IDW-1:0]  o_grant_id;
    logic            o_busy;
    logic            o_err_overflow;

    // FIFO stub
    int   f_cnt = 0;
    logic f_ovf_seen = 1'b0;
    logic fifo_full;
    logic fifo_af;
    assign fifo_full = (f_cnt >= DEPTH);
    assign fifo_af   = (f_cnt >= DEPTH - 1);

    always @(posedge clk) begin
        if (o_fifo_reset) begin
            f_cnt <= 0;
        end else begin
            if (o_fifo_wr_en && f_cnt >= DEPTH && !(rd && f_cnt > 0)) f_ovf_seen <= 1'b1;
            f_cnt <= f_cnt + (o_fifo_wr_en ? 1 : 0) - ((rd && f_cnt > 0) ? 1 : 0);
        end
    end

    fifo36k_wr_arbiter #(
        .NUM_REQ      (N),
        .DATA_WIDTH   (DW),
        .RESET_CYCLES (RC),
        .SETTLE_CYCLES(SC)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_req_valid       (valid),
        .i_req_data        (data_bus),
        .o_req_ready       (o_req_ready),
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
        .i_req_last        (last),
`endif
        .i_flush           (flush),
        .i_fifo_full       (fifo_full),
        .i_fifo_almost_full(fifo_af),
        .i_fifo_overflow   (ovf_in),
        .o_fifo_reset      (o_fifo_reset),
        .o_fifo_wr_en      (o_fifo_wr_en),
        .o_fifo_wr_data    (o_fifo_wr_data),
        .o_grant_id        (o_grant_id),
        .o_busy            (o_busy),
        .o_err_overflow    (o_err_overflow)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int             m_ptr, m_lock, m_busy_left, m_rst_left, m_acc_id;
    logic           m_wr_en, m_err, m_acc;
    logic [DW-1:0]  m_wr_data;
    logic [IDW-1:0] m_gid;
    logic [N-1:0]   m_ready;

    function automatic logic [OW-1:0] pack_obs();
        return {o_req_ready, o_fifo_wr_en, o_grant_id, o_busy, o_fifo_reset, o_err_overflow};
    endfunction

    function automatic logic [OW-1:0] pack_exp();
        return {m_ready, m_wr_en, m_gid, (m_busy_left > 0), (m_rst_left > 0), m_err};
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_lock = -1; m_busy_left = RC + SC; m_rst_left = RC;
        m_wr_en = 1'b0; m_err = 1'b0; m_wr_data = '0; m_gid = '0;
        m_ready = '0; m_acc = 1'b0; m_acc_id = 0;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic fl, input logic ov,
                         input logic r, input logic [N-1:0] l);
        valid = v; flush = fl; ovf_in = ov; rd = r; last = l;
        for (int i = 0; i < N; i++) begin
            req_data[i] = {4'(i), 32'($urandom())};
            data_bus[i*DW +: DW] = req_data[i];
        end
    endtask

    // Expected grant for the current inputs.
    task automatic eval_model();
        logic space;
        m_ready = '0; m_acc = 1'b0; m_acc_id = 0;
        space = !fifo_full && !(m_wr_en && fifo_af);
        if (m_busy_left == 0 && !flush && space) begin
            if (m_lock >= 0) begin
                if (valid[m_lock]) begin m_acc = 1'b1; m_acc_id = m_lock; end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_acc && valid[(m_ptr + k) % N]) begin
                        m_acc = 1'b1; m_acc_id = (m_ptr + k) % N;
                    end
                end
            end
        end
        if (m_acc) m_ready[m_acc_id] = 1'b1;
    endtask

    task automatic advance();
        @(posedge clk);
        m_wr_en = m_acc;
        if (m_acc) begin
            m_wr_data = req_data[m_acc_id];
            m_gid = IDW'(m_acc_id);
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
            if (last[m_acc_id]) begin m_ptr = (m_acc_id + 1) % N; m_lock = -1; end
            else m_lock = m_acc_id;
`else
            m_ptr = (m_acc_id + 1) % N;
`endif
        end
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_rst_left > 0) m_rst_left--;
        end else if (flush) begin
            m_busy_left = RC + SC; m_rst_left = RC; m_err = 1'b0; m_lock = -1;
        end else if (ovf_in) begin
            m_err = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive('1, 1'b0, 1'b0, 1'b0, '0);
        #1;
        n_checks++;
        if ({o_req_ready, o_fifo_wr_en, o_grant_id, o_busy, o_fifo_reset, o_err_overflow}
            !== {4'b0000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL reset values: got %b want %b",
                     {o_req_ready, o_fifo_wr_en, o_grant_id, o_busy, o_fifo_reset,
                      o_err_overflow}, 10'b0000000110);
        end
        n_checks++;
        if (o_fifo_wr_data !== '0) begin
            n_errors++;
            $display("FAIL reset wr_data: got %h want 0", o_fifo_wr_data);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive('1, 1'b0, 1'b0, 1'b0, '1);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL reset_seq cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            n_checks++;
            if ((o_req_ready != '0) !== (k >= RC + SC)) begin
                n_errors++;
                $display("FAIL first_ready cyc %0d: got ready %b want granted=%0d",
                         k, o_req_ready, (k >= RC + SC));
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        int rr_exp;
        rr_exp = m_ptr;
        for (int k = 0; k < 20; k++) begin
            drive('1, 1'b0, 1'b0, 1'b0, '1);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL rr ctrl cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            if (m_wr_en) begin
                n_checks++;
                if (o_fifo_wr_data !== m_wr_data) begin
                    n_errors++;
                    $display("FAIL rr data: got %h want %h", o_fifo_wr_data, m_wr_data);
                end
            end
            if (k >= 1) begin
                n_checks++;
                if ({o_fifo_wr_en, o_fifo_wr_data[DW-1 -: 4], o_grant_id}
                    !== {1'b1, 4'(rr_exp), 2'(rr_exp)}) begin
                    n_errors++;
                    $display("FAIL rr order cyc %0d: got en=%b tag=%0d id=%0d want tag/id %0d",
                             k, o_fifo_wr_en, o_fifo_wr_data[DW-1 -: 4], o_grant_id, rr_exp);
                end
                rr_exp = (rr_exp + 1) % N;
            end
            advance();
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 10; k++) begin
            drive(4'b0101, 1'b0, (k == 4), 1'b0, '1);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL ovf cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            advance();
        end
        n_checks++;
        if (o_err_overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf sticky: got %b want 1", o_err_overflow);
        end
    endtask

    task automatic test_flush();
        int rst_hi, wr_busy;
        rst_hi = 0; wr_busy = 0;
        for (int k = 0; k < 14; k++) begin
            drive(4'b0101, (k == 3), 1'b0, 1'b0, '1);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL flush cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            if (m_wr_en) begin
                n_checks++;
                if (o_fifo_wr_data !== m_wr_data) begin
                    n_errors++;
                    $display("FAIL flush data: got %h want %h", o_fifo_wr_data, m_wr_data);
                end
            end
            if (k >= 4) begin
                if (o_fifo_reset) rst_hi++;
                if (k <= 4 + RC + SC && o_fifo_wr_en) wr_busy++;
            end
            if (k == 4) begin
                n_checks++;
                if (o_err_overflow !== 1'b0) begin
                    n_errors++;
                    $display("FAIL flush err clear: got %b want 0", o_err_overflow);
                end
            end
            advance();
        end
        n_checks++;
        if (rst_hi !== RC) begin
            n_errors++;
            $display("FAIL flush reset width: got %0d want %0d", rst_hi, RC);
        end
        n_checks++;
        if (wr_busy !== 0) begin
            n_errors++;
            $display("FAIL flush writes while busy: got %0d want 0", wr_busy);
        end
    endtask

    task automatic test_backpressure();
        int writes;
        writes = 0;
        for (int k = 0; k < 1112; k++) begin
            drive(((k == 0) ? '0 : '1), (k == 0), 1'b0, (k == 1100), '1);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL bp cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            if (k >= 1 && o_fifo_wr_en) writes++;
            if (k == 1099) begin
                n_checks++;
                if ({writes, o_req_ready, o_err_overflow, f_ovf_seen}
                    !== {32'(DEPTH), 4'b0000, 1'b0, 1'b0}) begin
                    n_errors++;
                    $display("FAIL bp fill: got writes=%0d ready=%b err=%b ovf=%b want %0d/0/0/0",
                             writes, o_req_ready, o_err_overflow, f_ovf_seen, DEPTH);
                end
            end
            advance();
        end
        n_checks++;
        if (writes !== DEPTH + 1) begin
            n_errors++;
            $display("FAIL bp after read: got writes=%0d want %0d", writes, DEPTH + 1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(N'($urandom()), ($urandom_range(0, 39) == 0), ($urandom_range(0, 59) == 0),
                  1'($urandom()), N'($urandom()));
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL rand cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            if (m_wr_en) begin
                n_checks++;
                if (o_fifo_wr_data !== m_wr_data) begin
                    n_errors++;
                    $display("FAIL rand data: got %h want %h", o_fifo_wr_data, m_wr_data);
                end
            end
            advance();
        end
        n_checks++;
        if (f_ovf_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL rand fifo overwritten: got %b want 0", f_ovf_seen);
        end
    endtask

`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
    task automatic test_burst_lock();
        logic [N-1:0] tv [17];
        logic [N-1:0] tl [17];
        int gids [$];
        int r0_grants;
        r0_grants = 0;
        // flush + settle, one req0 beat to move the pointer to 1, then the burst
        for (int k = 0; k < 9; k++) begin tv[k] = '0; tl[k] = '1; end
        tv[8] = 4'b0001;
        tv[9]  = 4'b0011; tl[9]  = 4'b0000;
        tv[10] = 4'b0001; tl[10] = 4'b0000;
        tv[11] = 4'b0011; tl[11] = 4'b0000;
        tv[12] = 4'b0011; tl[12] = 4'b0010;
        tv[13] = 4'b0011; tl[13] = 4'b0001;
        for (int k = 14; k < 17; k++) begin tv[k] = '0; tl[k] = '1; end
        for (int k = 0; k < 17; k++) begin
            drive(tv[k], (k == 0), 1'b0, 1'b0, tl[k]);
            @(negedge clk);
            eval_model();
            n_checks++;
            if (pack_obs() !== pack_exp()) begin
                n_errors++;
                $display("FAIL lock cyc %0d: got %b want %b", k, pack_obs(), pack_exp());
            end
            if (k >= 9 && k <= 12 && o_req_ready[0]) r0_grants++;
            if (k >= 10 && o_fifo_wr_en) gids.push_back(int'(o_grant_id));
            advance();
        end
        n_checks++;
        if (gids.size() !== 4 || gids[0] !== 1 || gids[1] !== 1 || gids[2] !== 1
            || gids[3] !== 0) begin
            n_errors++;
            $display("FAIL lock order: got %p want '{1,1,1,0}", gids);
        end
        n_checks++;
        if (r0_grants !== 0) begin
            n_errors++;
            $display("FAIL lock req0 during burst: got %0d grants want 0", r0_grants);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_overflow();
        test_flush();
        test_backpressure();
        test_random();
        test_reset();
`ifdef FIFO36K_WR_ARB_BURST_LOCK_EN
        test_burst_lock();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
